// File: rtl/weight_mult_array.sv
`default_nettype none
// ============================================================================
// Module      : weight_mult_array
// Description : Latches one window of pixel/weight pairs on a start pulse and
//               forms one product per clock on a shared multiplier, then
//               presents the packed product vector with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_mult_array #(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 1
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic                                              mult_en,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]                 mult_dataIn,
  input  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]               mult_weightIn,
  output logic                                              mult_busy,
  output logic [(DATA_WIDTH+WEIGHT_WIDTH)*KERNEL_SIZE-1:0]  mult_dataOut,
  output logic                                              mult_done
);

  localparam int RESULT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int IDX_W        = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                                    r_state;
  logic [IDX_W-1:0]                          r_idx;
  logic [DATA_WIDTH*KERNEL_SIZE-1:0]         r_data;
  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]       r_weight;
  logic [RESULT_WIDTH*KERNEL_SIZE-1:0]       r_shadow;

  logic [DATA_WIDTH-1:0]                     w_data_sel;
  logic [WEIGHT_WIDTH-1:0]                   w_weight_sel;
  logic [RESULT_WIDTH-1:0]                   w_product;
  logic [RESULT_WIDTH*KERNEL_SIZE-1:0]       w_shadow_next;

  assign w_data_sel   = r_data[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_weight_sel = r_weight[r_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  // Operands are widened first so the full product is kept.
  assign w_product    = RESULT_WIDTH'(w_data_sel) * RESULT_WIDTH'(w_weight_sel);

  // Shadow with the current slot merged, so the last product can be published
  // on the same edge it is computed.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[r_idx*RESULT_WIDTH +: RESULT_WIDTH] = w_product;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_data       <= '0;
      r_weight     <= '0;
      r_shadow     <= '0;
      mult_dataOut <= '0;
      mult_done    <= 1'b0;
      mult_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          mult_done <= 1'b0;
          if (mult_en) begin
            r_data    <= mult_dataIn;
            r_weight  <= mult_weightIn;
            r_idx     <= '0;
            mult_busy <= 1'b1;
            r_state   <= MULT;
          end
        end
        MULT: begin
          r_shadow <= w_shadow_next;
          if (r_idx == c_LAST_IDX) begin
            mult_dataOut <= w_shadow_next;
            mult_done    <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          mult_done <= 1'b0;
          mult_busy <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          mult_done <= 1'b0;
          mult_busy <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
